// File: rtl/vec_issue_sequencer_if.sv
// Bundle for the vector issue sequencer. It carries the ID-stage instruction inputs,
// the downstream stall and flush inputs, and the per-beat outputs to the VRF and lanes.
interface vec_issue_sequencer_if #(
  parameter int IDXW = 3
);
  logic            valid_i;
  logic [6:0]      opcode_i;
  logic [4:0]      vd_i;
  logic [4:0]      vs1_i;
  logic [4:0]      vs2_i;
  logic            ext_stall_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            vrf_we_o;
  logic [4:0]      vd_o;
  logic [4:0]      vs1_o;
  logic [4:0]      vs2_o;
  logic [IDXW-1:0] elem_base_o;
  logic            done_o;
  logic [1:0]      state_o;

  // Handshake: an instruction is accepted in any cycle where valid_i is high, opcode_i
  // is the vector opcode, flush_i is low and the sequencer is not BUSY. stall_o is the
  // back-pressure toward IF/ID and is high in the accepting cycle and in every BUSY
  // cycle. A beat is written in each cycle where vrf_we_o is high.
  modport slave (
    input  valid_i, opcode_i, vd_i, vs1_i, vs2_i, ext_stall_i, flush_i,
    output stall_o, busy_o, vrf_we_o, vd_o, vs1_o, vs2_o, elem_base_o, done_o, state_o
  );

  modport master (
    output valid_i, opcode_i, vd_i, vs1_i, vs2_i, ext_stall_i, flush_i,
    input  stall_o, busy_o, vrf_we_o, vd_o, vs1_o, vs2_o, elem_base_o, done_o, state_o
  );
endinterface

// File: rtl/vec_issue_sequencer.sv
// Steps one accepted vector instruction through ELEMS/LANES element-group beats,
// stalling the front end until the last beat issues and then pulsing done for one cycle.
module vec_issue_sequencer #(
  parameter int ELEMS = 8,
  parameter int LANES = 2
) (
  input logic clk_i,
  input logic rst_i,
  vec_issue_sequencer_if.slave bus
);
  localparam int BEATS = ELEMS / LANES;
  localparam int IDXW  = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [6:0]    VEC_OP    = 7'b1010111;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [BW-1:0]   r_beat;
  logic [4:0]      r_vd;
  logic [4:0]      r_vs1;
  logic [4:0]      r_vs2;

  logic            w_start;
  logic            w_busy;
  logic [IDXW-1:0] w_elem_base;

  assign w_start     = bus.valid_i & (bus.opcode_i == VEC_OP) & ~bus.flush_i;
  assign w_busy      = (r_state == S_BUSY);
  assign w_elem_base = IDXW'(r_beat) * IDXW'(LANES);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_vd    <= '0;
      r_vs1   <= '0;
      r_vs2   <= '0;
    end else begin
      case (r_state)
        S_BUSY: begin
          if (bus.flush_i) begin
            r_state <= S_IDLE;
          end else if (bus.ext_stall_i) begin
            r_state <= S_BUSY;
          end else if (r_beat == LAST_BEAT) begin
            r_state <= S_DONE;
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
        // IDLE and DONE both accept; DONE falls back to IDLE when nothing arrives.
        default: begin
          if (w_start) begin
            r_state <= S_BUSY;
            r_beat  <= '0;
            r_vd    <= bus.vd_i;
            r_vs1   <= bus.vs1_i;
            r_vs2   <= bus.vs2_i;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // stall_o and vrf_we_o stay combinational so the accepting cycle holds IF/ID
  // and a flush or downstream stall suppresses the write in the same cycle.
  assign bus.stall_o     = w_busy | (w_start & (r_state != S_BUSY));
  assign bus.busy_o      = w_busy;
  assign bus.vrf_we_o    = w_busy & ~bus.ext_stall_i & ~bus.flush_i;
  assign bus.elem_base_o = w_busy ? w_elem_base : '0;
  assign bus.done_o      = (r_state == S_DONE);
  assign bus.vd_o        = r_vd;
  assign bus.vs1_o       = r_vs1;
  assign bus.vs2_o       = r_vs2;
  assign bus.state_o     = r_state;
endmodule

// File: doc/vec_issue_sequencer.md
Name: vec_issue_sequencer

Overview:
Multi-cycle sequencer for vector-class instructions (opcode 7'b1010111) decoded by the main control unit. It accepts one vector instruction, holds the front end with a stall, and steps the vector register file and lane ALUs through ELEMS/LANES element-group beats. It sits beside the main decoder in the ID/EX boundary. It also handles pipeline back-pressure and flush.

Parameters:
ELEMS, 8, elements per vector register; must be a power of two.
LANES, 2, elements processed per beat; must divide ELEMS.
BEATS (localparam), ELEMS/LANES, beats per instruction; must be ≥1.
IDXW (localparam), max(1,$clog2(ELEMS)), width of elem_base_o.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous reset, active-high
valid_i  input  1  ID-stage instruction valid
opcode_i  input  7  ID-stage opcode
vd_i  input  5  destination vector register index
vs1_i  input  5  source 1 vector register index
vs2_i  input  5  source 2 vector register index
ext_stall_i  input  1  downstream stall; freezes beat progress
flush_i  input  1  pipeline flush; aborts the current or incoming instruction
stall_o  output  1  hold PC and IF/ID
busy_o  output  1  state is BUSY
vrf_we_o  output  1  vector register file write enable for the current beat
vd_o  output  5  latched vd
vs1_o  output  5  latched vs1
vs2_o  output  5  latched vs2
elem_base_o  output  IDXW  first element index of the current beat, = beat*LANES
done_o  output  1  single-cycle completion pulse

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, beat=0, vd/vs1/vs2 latches=0. All outputs read 0 from the next cycle. rst_i has priority over every other input, including mid-BUSY; an aborted instruction produces no done_o.
- start = valid_i & (opcode_i==7'b1010111) & ~flush_i. Evaluated in IDLE and DONE only.
- States: IDLE, BUSY, DONE.
- IDLE: on start, latch vd_i/vs1_i/vs2_i, set beat=0, go to BUSY. Otherwise stay.
- BUSY, priority order:
  - flush_i → IDLE; vrf_we_o=0 that cycle.
  - ext_stall_i → hold beat; vrf_we_o=0.
  - beat==BEATS-1 → DONE.
  - otherwise beat+1.
- DONE: done_o=1 for exactly one cycle. On start (back-to-back vector instruction), latch new indices and go to BUSY with beat=0. Otherwise go to IDLE.
- stall_o = (start & state∈{IDLE,DONE}) | (state==BUSY). Combinational, so the accepting cycle stalls the front end. stall_o=0 in DONE unless a new start arrives.
- vrf_we_o = (state==BUSY) & ~ext_stall_i & ~flush_i.
- busy_o = (state==BUSY).
- elem_base_o = beat*LANES in BUSY, 0 otherwise. No wrap: beat never exceeds BEATS-1.
- vd_o/vs1_o/vs2_o hold their last latched value until the next accept.
- Latency with no stalls: accept at cycle T, write beats at T+1..T+BEATS, done_o at T+BEATS+1. stall_o is high for BEATS+1 cycles (T..T+BEATS).
- ext_stall_i while in IDLE or DONE has no effect on accept.
- Non-vector opcodes never change state.
- BEATS==1: BUSY lasts one cycle.

Test Plan:
- Defaults. Reset, then valid_i=1, opcode=7'b1010111, vd=3, vs1=1, vs2=2 at T → stall_o=1 at T..T+4; vrf_we_o=1 at T+1..T+4 with elem_base_o=0,2,4,6; vd_o=3; done_o=1 only at T+5; stall_o=0 at T+5.
- Same start, ext_stall_i=1 at T+2 and T+3 → vrf_we_o=0 and elem_base_o=2 held over T+2..T+4; elem_base_o 4,6 at T+5,T+6; done_o at T+7.
- flush_i=1 at T+2 → vrf_we_o=0 at T+2; IDLE at T+3; done_o never asserts; stall_o=0 at T+3.
- Second vector instruction (vd=7) presented at the DONE cycle T+5 → accepted; stall_o=1 at T+5; vd_o=7; beats at T+6..T+9; done_o at T+10.
- Non-vector opcode 7'b0110011 with valid_i=1, and vector opcode with flush_i=1 → no state change; stall_o=0; vrf_we_o=0.
- rst_i=1 at T+2 mid-BUSY → all outputs 0 from T+3; no done_o; a new start at T+4 is accepted normally.
